// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns the PC, drives RAM fetches,
// evaluates condition codes and sequences write-back and load/store.
module instr_sequencer #(
  parameter int         PC_WIDTH    = 8,
  parameter logic [3:0] OP_LDR      = 4'b1000,
  parameter logic [3:0] OP_STR      = 4'b1001,
  parameter logic [3:0] OP_B        = 4'b1010,
  parameter logic [3:0] OP_HALT     = 4'b1111,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  output logic                Ram_Enable,
  output logic                Ram_RW,
  output logic [15:0]         Ram_Address,
  input  logic [31:0]         Ram_Data,
  output logic [31:0]         Instr,
  input  logic [3:0]          New_Flag,
  output logic [3:0]          Flag,
  output logic                Reg_Write,
  output logic                Mem_Req,
  input  logic                Mem_Ready,
  output logic [PC_WIDTH-1:0] Pc,
  output logic [15:0]         Instr_Count,
  output logic                Halted,
  output logic                Error
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_instr;
  logic [3:0]          r_flag;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_cnt;
  logic [TW-1:0]       r_tmo;
  logic                r_err;

  logic                w_cond;
  logic [3:0]          w_op;
  logic [PC_WIDTH-1:0] w_off;
  logic                w_n, w_z, w_c, w_v;
  logic                w_latch, w_adv, w_br;
  logic                w_flag_we, w_tmo_clr, w_err_set;
  logic                w_alu_op;

  assign w_op  = r_instr[27:24];
  assign w_off = PC_WIDTH'($signed(r_instr[10:3]));
  assign {w_n, w_z, w_c, w_v} = r_flag;
  assign w_alu_op = (w_op != OP_LDR) && (w_op != OP_STR) &&
                    (w_op != OP_B);

  always_comb begin
    w_cond = 1'b0;
    unique case (r_instr[31:28])
      4'h0: w_cond = w_z;
      4'h1: w_cond = !w_z;
      4'h2: w_cond = w_c;
      4'h3: w_cond = !w_c;
      4'h4: w_cond = w_n;
      4'h5: w_cond = !w_n;
      4'h6: w_cond = w_v;
      4'h7: w_cond = !w_v;
      4'h8: w_cond = w_c && !w_z;
      4'h9: w_cond = !w_c || w_z;
      4'hA: w_cond = (w_n == w_v);
      4'hB: w_cond = (w_n != w_v);
      4'hC: w_cond = !w_z && (w_n == w_v);
      4'hD: w_cond = w_z || (w_n != w_v);
      4'hE: w_cond = 1'b1;
      4'hF: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_adv     = 1'b0;
    w_br      = 1'b0;
    w_flag_we = 1'b0;
    w_tmo_clr = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE: if (Start) w_next = S_FETCH;
      S_FETCH: begin
        w_latch = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        if (!w_cond) begin
          w_adv  = 1'b1;
          w_next = S_FETCH;
        end else if (w_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_flag_we = r_instr[23];
        if (w_op == OP_B) begin
          w_br   = 1'b1;
          w_next = S_FETCH;
        end else if (!w_alu_op) begin
          w_tmo_clr = 1'b1;
          w_next    = S_MEM;
        end else begin
          w_adv  = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        // Ready takes priority over a timeout expiring in the same cycle
        if (Mem_Ready) begin
          if (w_op == OP_LDR) begin
            w_next = S_WB;
          end else begin
            w_adv  = 1'b1;
            w_next = S_FETCH;
          end
        end else if (r_tmo == TW'(MEM_TIMEOUT - 1)) begin
          w_err_set = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        w_adv  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_flag  <= '0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch)   r_instr <= Ram_Data;
      if (w_flag_we) r_flag  <= New_Flag;
      if (w_adv)     r_pc    <= r_pc + PC_WIDTH'(1);
      else if (w_br) r_pc    <= r_pc + w_off;
      if (w_adv || w_br) r_cnt <= r_cnt + 16'd1;
      if (w_tmo_clr)
        r_tmo <= '0;
      else if (r_state == S_MEM)
        r_tmo <= r_tmo + TW'(1);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign Ram_Enable  = (r_state == S_FETCH);
  assign Ram_RW      = 1'b1;
  assign Ram_Address = 16'(r_pc);
  assign Instr       = r_instr;
  assign Flag        = r_flag;
  assign Reg_Write   = ((r_state == S_EXEC) && w_alu_op) ||
                       (r_state == S_WB);
  assign Mem_Req     = (r_state == S_MEM);
  assign Pc          = r_pc;
  assign Instr_Count = r_cnt;
  assign Halted      = (r_state == S_HALT);
  assign Error       = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: RAM model, Mem_Ready responder,
// per-instruction latency and state checks.
module tb_instr_sequencer;

  logic        Clk, Reset, Start;
  logic        Ram_Enable, Ram_RW;
  logic [15:0] Ram_Address;
  logic [31:0] Ram_Data, Instr;
  logic [3:0]  New_Flag, Flag;
  logic        Reg_Write, Mem_Req, Mem_Ready;
  logic [7:0]  Pc;
  logic [15:0] Instr_Count;
  logic        Halted, Error;

  logic [31:0] ram [256];
  int          ready_delay;
  int          mem_cyc;
  int          n_vec, n_bad;
  int          cyc, nrw, nmr;

  instr_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Ram_Enable(Ram_Enable), .Ram_RW(Ram_RW),
    .Ram_Address(Ram_Address), .Ram_Data(Ram_Data),
    .Instr(Instr), .New_Flag(New_Flag), .Flag(Flag),
    .Reg_Write(Reg_Write), .Mem_Req(Mem_Req),
    .Mem_Ready(Mem_Ready), .Pc(Pc),
    .Instr_Count(Instr_Count), .Halted(Halted),
    .Error(Error)
  );

  assign Ram_Data = ram[Ram_Address[7:0]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Assert Mem_Ready in the ready_delay-th MEM cycle (0 = never)
  always @(negedge Clk) begin
    if (Mem_Req) begin
      mem_cyc++;
      Mem_Ready = (ready_delay != 0) && (mem_cyc == ready_delay);
    end else begin
      mem_cyc   = 0;
      Mem_Ready = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic go;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // From a sampled FETCH cycle, run until the next FETCH or HALT
  task automatic run_instr(output int c, output int rw,
                           output int mr);
    int both;
    c = 0; rw = 0; mr = 0; both = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      c++;
      if (Ram_Enable || Halted) break;
      if (Reg_Write) rw++;
      if (Mem_Req) mr++;
      if (Reg_Write && Mem_Req) both++;
    end
    chk("bound", {31'd0, Ram_Enable | Halted}, 32'd1);
    chk("rw_mr_excl", both, 0);
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    step();
    step();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
  endtask

  task automatic run_chk(input string tag, input int ec,
                         input int erw, input int emr,
                         input logic [7:0] epc,
                         input logic [15:0] ecnt);
    run_instr(cyc, nrw, nmr);
    chk({tag, "_cyc"}, cyc, ec);
    chk({tag, "_rw"}, nrw, erw);
    chk({tag, "_mr"}, nmr, emr);
    chk({tag, "_pc"}, Pc, epc);
    chk({tag, "_cnt"}, Instr_Count, ecnt);
    chk({tag, "_addr"}, Ram_Address, {8'd0, epc});
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    Reset = 1'b0; Start = 1'b0; New_Flag = 4'h0;
    ready_delay = 0; mem_cyc = 0; Mem_Ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]   = 32'hE0000000;
    ram[1]   = 32'hE0800000;
    ram[2]   = 32'h10800000;
    ram[3]   = 32'hE0800000;
    ram[4]   = 32'hB0000000;
    ram[5]   = 32'hA0000000;
    ram[6]   = 32'hEA000020;
    ram[10]  = 32'hEA0007F0;
    ram[8]   = 32'hE8000000;
    ram[9]   = 32'hEA000058;
    ram[20]  = 32'hE9000000;
    ram[21]  = 32'hEA000750;
    ram[255] = 32'hE0000000;

    do_reset();
    chk("rst_pc", Pc, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_flag", Flag, 0);
    chk("rst_cnt", Instr_Count, 0);
    chk("rst_strb", {Ram_Enable, Reg_Write, Mem_Req}, 0);
    chk("rst_hlt_err", {Halted, Error}, 0);
    chk("rst_rw_addr", {Ram_RW, Ram_Address}, 32'h10000);
    step();
    chk("idle_quiet", {Ram_Enable, Reg_Write, Mem_Req}, 0);

    go();
    chk("fetch0_en", Ram_Enable, 1);
    chk("fetch0_addr", Ram_Address, 0);
    run_chk("alu0", 3, 1, 0, 8'd1, 16'd1);
    New_Flag = 4'b0100;
    run_chk("setz", 3, 1, 0, 8'd2, 16'd2);
    chk("flag_z", Flag, 4'b0100);
    New_Flag = 4'b1111;
    run_chk("ne_skip", 2, 0, 0, 8'd3, 16'd3);
    chk("flag_keep", Flag, 4'b0100);
    New_Flag = 4'b1001;
    run_chk("setnv", 3, 1, 0, 8'd4, 16'd4);
    chk("flag_nv", Flag, 4'b1001);
    New_Flag = 4'b0000;
    run_chk("lt_skip", 2, 0, 0, 8'd5, 16'd5);
    run_chk("ge_exec", 3, 1, 0, 8'd6, 16'd6);
    chk("flag_s0", Flag, 4'b1001);
    run_chk("b_fwd", 3, 0, 0, 8'd10, 16'd7);
    run_chk("b_back", 3, 0, 0, 8'd8, 16'd8);
    ready_delay = 3;
    run_chk("ldr", 7, 1, 3, 8'd9, 16'd9);
    chk("ldr_instr", Instr, 32'hE8000000);
    run_chk("b_far", 3, 0, 0, 8'd20, 16'd10);
    ready_delay = 1;
    run_chk("str", 4, 0, 1, 8'd21, 16'd11);
    run_chk("b_wrap", 3, 0, 0, 8'd255, 16'd12);
    run_chk("pc_wrap", 3, 1, 0, 8'd0, 16'd13);

    ready_delay = 0;
    ram[0] = 32'hE8000000;
    do_reset();
    go();
    run_instr(cyc, nrw, nmr);
    chk("tmo_mr", nmr, 15);
    chk("tmo_cyc", cyc, 18);
    chk("tmo_hlt_err", {Halted, Error}, 2'b11);
    chk("tmo_pc", Pc, 0);
    chk("tmo_cnt", Instr_Count, 0);
    Start = 1'b1;
    repeat (3) step();
    Start = 1'b0;
    chk("tmo_stay", {Halted, Error, Mem_Req}, 3'b110);

    do_reset();
    chk("rst_err_clr", {Halted, Error}, 0);
    go();
    repeat (4) step();
    chk("mid_mem_req", Mem_Req, 1);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("amid_strb", {Ram_Enable, Reg_Write, Mem_Req}, 0);
    chk("amid_instr", Instr, 0);
    chk("amid_pc_cnt", {Pc, Instr_Count}, 0);
    chk("amid_hlt_err", {Halted, Error}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;

    ram[0] = 32'hE0000000;
    ram[1] = 32'hEF000000;
    go();
    run_chk("pre_halt", 3, 1, 0, 8'd1, 16'd1);
    run_instr(cyc, nrw, nmr);
    chk("halt_cyc", cyc, 2);
    chk("halt_rw", nrw, 0);
    chk("halt_hlt", Halted, 1);
    chk("halt_pc", Pc, 1);
    Start = 1'b1;
    repeat (3) step();
    Start = 1'b0;
    chk("halt_stay", {Halted, Ram_Enable, Reg_Write, Mem_Req}, 4'b1000);
    chk("halt_pc2", Pc, 1);
    chk("halt_cnt", Instr_Count, 1);
    chk("halt_err", Error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
